// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between requesters (master) and the arbiter (slave)
//   req       4  request lines, req[i] asks for grant Di
//   D0..D3    1  registered one-hot grant
//   gnt_valid 1  high when any Di is high
//   lock      1  grant lock, only with RR_ARB_LOCK_EN
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       D0, D1, D2, D3;
    logic       gnt_valid;
`ifdef RR_ARB_LOCK_EN
    logic       lock;
    modport master (output req, lock, input D0, D1, D2, D3, gnt_valid);
    modport slave  (input req, lock, output D0, D1, D2, D3, gnt_valid);
`else
    modport master (output req, input D0, D1, D2, D3, gnt_valid);
    modport slave  (input req, output D0, D1, D2, D3, gnt_valid);
`endif
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-requester round-robin arbiter with bounded grant hold
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter4_if.slave: req in, D0..D3 / gnt_valid out (lock in with RR_ARB_LOCK_EN)
//   HOLD_CYCLES  max cycles an owner keeps the grant under contention (1..255)
//   Macro RR_ARB_LOCK_EN adds the lock input that suppresses preemption.
module rr_arbiter4 #(
    parameter int HOLD_CYCLES = 4
) (
    input logic         clk,
    input logic         rst_n,
    rr_arbiter4_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HMAX = 8'(HOLD_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] g, g_n, ptr, ptr_n;
    logic [7:0] hcnt, hcnt_n;
    logic [3:0] grant;
    logic       valid;
    logic       lk;
    logic [2:0] from_ptr, from_next;
    logic       others;

`ifdef RR_ARB_LOCK_EN
    assign lk = bus.lock;
`else
    assign lk = 1'b0;
`endif

    // {found, index} of the first requester at or after start, modulo 4
    function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] s);
        logic [2:0] res;
        logic [1:0] i;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            i = s + 2'(k);
            if (r[i]) res = {1'b1, i};
        end
        return res;
    endfunction

    assign from_ptr  = search(bus.req, ptr);
    assign from_next = search(bus.req, g + 2'd1);
    assign others    = |(bus.req & ~(4'b0001 << g));

    always_comb begin
        state_n = state;
        g_n     = g;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        if (state == IDLE) begin
            if (|bus.req) begin
                state_n = GRANT;
                g_n     = from_ptr[1:0];
                hcnt_n  = '0;
            end
        end else if (!bus.req[g]) begin
            // release: hand off in the same edge, or fall back to idle
            ptr_n   = g + 2'd1;
            hcnt_n  = '0;
            g_n     = from_next[1:0];
            state_n = from_next[2] ? GRANT : IDLE;
        end else if (hcnt == HMAX && others && !lk) begin
            // others exist so search from g+1 cannot land back on g
            g_n    = from_next[1:0];
            ptr_n  = g + 2'd1;
            hcnt_n = '0;
        end else begin
            hcnt_n = (hcnt == HMAX) ? hcnt : hcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
            hcnt  <= '0;
            grant <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            g     <= g_n;
            ptr   <= ptr_n;
            hcnt  <= hcnt_n;
            grant <= (state_n == GRANT) ? 4'b0001 << g_n : 4'b0000;
            valid <= state_n == GRANT;
        end
    end

    assign bus.D0        = grant[0];
    assign bus.D1        = grant[1];
    assign bus.D2        = grant[2];
    assign bus.D3        = grant[3];
    assign bus.gnt_valid = valid;
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed scoreboard bench for rr_arbiter4 (HOLD_CYCLES 4 and 1)
module tb_rr_arbiter4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] exp_q[$];

    rr_arbiter4_if ifc();
    rr_arbiter4_if ifc1();

    rr_arbiter4 #(.HOLD_CYCLES(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
    rr_arbiter4 #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    always #5 clk = ~clk;

    function automatic logic [4:0] observed(input logic sel);
        return sel ? {ifc1.gnt_valid, ifc1.D3, ifc1.D2, ifc1.D1, ifc1.D0}
                   : {ifc.gnt_valid, ifc.D3, ifc.D2, ifc.D1, ifc.D0};
    endfunction

    task automatic check_now(input logic sel, input logic [3:0] e, input string tag);
        logic [4:0] o;
        logic [4:0] x;
        o = observed(sel);
        x = {|e, e};
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, x);
        end
    endtask

    task automatic set_lock(input logic l);
`ifdef RR_ARB_LOCK_EN
        ifc.lock  = l;
        ifc1.lock = l;
`else
        if (l) $display("lock not built in");
`endif
    endtask

    // drive req, queue the expected grant, compare it one edge later
    task automatic step(input logic sel, input logic [3:0] r, input logic [3:0] e, input string tag);
        ifc.req  = r;
        ifc1.req = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_now(sel, exp_q.pop_front(), tag);
    endtask

    task automatic do_reset();
        ifc.req  = '0;
        ifc1.req = '0;
        rst_n = 1'b0;
        #2;
        check_now(0, 4'b0000, "reset0");
        check_now(1, 4'b0000, "reset1");
        rst_n = 1'b1;
    endtask

    initial begin
        ifc.req  = '0;
        ifc1.req = '0;
        set_lock(1'b0);
        #3;
        do_reset();

        step(0, 4'b0100, 4'b0100, "single");
        step(0, 4'b0000, 4'b0000, "idle");

        do_reset();
        for (int k = 0; k < 4; k++) step(0, 4'b1111, 4'b0001, "rot_d0");
        for (int k = 0; k < 4; k++) step(0, 4'b1111, 4'b0010, "rot_d1");
        for (int k = 0; k < 4; k++) step(0, 4'b1111, 4'b0100, "rot_d2");
        for (int k = 0; k < 4; k++) step(0, 4'b1111, 4'b1000, "rot_d3");
        step(0, 4'b1111, 4'b0001, "rot_wrap");

        step(0, 4'b1010, 4'b0010, "handoff_d1");
        step(0, 4'b1010, 4'b0010, "hold_d1");
        step(0, 4'b1000, 4'b1000, "handoff_d3");
        step(0, 4'b0000, 4'b0000, "release_idle");

        for (int k = 0; k < 20; k++) step(0, 4'b0100, 4'b0100, "sole_d2");

        step(0, 4'b1000, 4'b1000, "pre_reset_d3");
        rst_n = 1'b0;
        #1;
        check_now(0, 4'b0000, "async_clear");
        #1;
        rst_n = 1'b1;
        step(0, 4'b1000, 4'b1000, "post_reset_d3");

        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 4'b1001, 4'b0001, "h1_d0");
            step(1, 4'b1001, 4'b1000, "h1_d3");
        end

`ifdef RR_ARB_LOCK_EN
        do_reset();
        set_lock(1'b1);
        for (int k = 0; k < 10; k++) step(0, 4'b0011, 4'b0001, "lock_hold");
        set_lock(1'b0);
        step(0, 4'b0011, 4'b0010, "unlock_d1");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
